// File: rtl/mux_bus_if.sv
// Bundles the request/response handshake and the multiplexed bus pins of
// mux_bus_master.
//   master modport: the bus master's view (drives strobes, bus_out, bus_oe,
//                   and the response pulses).
//   slave  modport: the requester/peripheral view of the same wires.
// DATA_W and BL_W must match the parameters of the attached master.
interface mux_bus_if #(
  parameter int DATA_W = 8,
  parameter int BL_W   = 3
);
  logic              start;
  logic              write;
  logic [DATA_W-1:0] addr;
  logic [BL_W-1:0]   burst_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ack;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              done;
  logic              CS;
  logic              RD;
  logic              WR;
  logic              AD;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;

  modport master (
    input  start, write, addr, burst_len, wdata, bus_in,
    output wdata_ack, rdata, rdata_valid, busy, done,
           CS, RD, WR, AD, bus_out, bus_oe
  );

  modport slave (
    output start, write, addr, burst_len, wdata, bus_in,
    input  wdata_ack, rdata, rdata_valid, busy, done,
           CS, RD, WR, AD, bus_out, bus_oe
  );
endinterface

// File: rtl/mux_bus_master.sv
// Master for a multiplexed address/data parallel bus with active-low CS, RD,
// WR and AD strobes. Runs single or burst read/write transactions requested
// through start/done, incrementing the address on every beat. Every phase
// length is a parameter. The tri-state pad is built outside from
// bus_out/bus_oe/bus_in.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high
//   bus    - mux_bus_if.master: request (start/write/addr/burst_len/wdata),
//            response (wdata_ack/rdata/rdata_valid/busy/done), bus pins
//            (CS/RD/WR/AD/bus_out/bus_oe/bus_in)
//   state  - current FSM state, for debug
//
// state  | meaning
// IDLE   | waiting for start, bus released
// TURN_A | AD low, address driven, before CS falls
// ADDR   | address phase: CS and WR low, AD low
// TURN_B | strobes released, address still driven
// HIZ    | bus released before the data phase
// XFER   | read or write strobe phase
// RECOV  | recovery after each beat; next beat or done
module mux_bus_master #(
  parameter int DATA_W  = 8,
  parameter int BL_W    = 3,
  parameter int T_TURN  = 5,
  parameter int T_ADDR  = 25,
  parameter int T_HIZ   = 25,
  parameter int T_DATA  = 25,
  parameter int T_RECOV = 25,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       reset,
  mux_bus_if.master  bus,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_TURN_A = 3'b001,
    S_ADDR   = 3'b010,
    S_TURN_B = 3'b011,
    S_HIZ    = 3'b100,
    S_XFER   = 3'b101,
    S_RECOV  = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(T_TURN - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] HIZ_LAST   = CNT_W'(T_HIZ - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(T_DATA - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(T_RECOV - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BL_W-1:0]   beats_q, beats_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              rvalid_q, rvalid_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d, oe_q, oe_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    ack_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_TURN_A;
          write_d = bus.write;
          addr_d  = bus.addr;
          beats_d = bus.burst_len;
          if (bus.write) begin
            wdata_d = bus.wdata;
            ack_d   = 1'b1;
          end
        end
      end
      S_TURN_A: if (cnt_q == TURN_LAST) state_d = S_ADDR;
      S_ADDR:   if (cnt_q == ADDR_LAST) state_d = S_TURN_B;
      S_TURN_B: if (cnt_q == TURN_LAST) state_d = S_HIZ;
      S_HIZ:    if (cnt_q == HIZ_LAST)  state_d = S_XFER;
      S_XFER: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_RECOV;
          if (!write_q) begin
            rdata_d  = bus.bus_in;
            rvalid_d = 1'b1;
          end
        end
      end
      S_RECOV: begin
        if (cnt_q == RECOV_LAST) begin
          if (beats_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_TURN_A;
            beats_d = beats_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            if (write_q) begin
              wdata_d = bus.wdata;
              ack_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state so they are registered
    // alongside it and change exactly on state transitions.
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    ad_d      = 1'b1;
    oe_d      = 1'b0;
    bus_out_d = bus_out_q;
    case (state_d)
      S_TURN_A, S_TURN_B: begin
        ad_d      = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = addr_d;
      end
      S_ADDR: begin
        cs_d      = 1'b0;
        wr_d      = 1'b0;
        ad_d      = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = addr_d;
      end
      S_XFER: begin
        cs_d = 1'b0;
        if (write_d) begin
          wr_d      = 1'b0;
          oe_d      = 1'b1;
          bus_out_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    // Counter restarts on every state entry; parked at zero while idle.
    cnt_d  = (state_d != state_q || state_d == S_IDLE) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      beats_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      rvalid_q  <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      ad_q      <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      rvalid_q  <= rvalid_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ad_q      <= ad_d;
      oe_q      <= oe_d;
    end
  end

  assign state           = state_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.wdata_ack   = ack_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.CS          = cs_q;
  assign bus.RD          = rd_q;
  assign bus.WR          = wr_q;
  assign bus.AD          = ad_q;
  assign bus.bus_out     = bus_out_q;
  assign bus.bus_oe      = oe_q;

endmodule

// File: tb/tb_mux_bus_master.sv
// Bench for mux_bus_master: one instance at default phase lengths (directed
// transactions, mid-write reset) and one with short phases (random bursts,
// back-to-back starts, spurious starts while busy). Expected pin values are
// derived per cycle from the phase-length arithmetic of a beat.
module tb_mux_bus_master;

  typedef struct packed {
    logic [2:0] st;
    logic       cs, rd, wr, ad, oe, busy, done, ack, rv;
    logic [7:0] rdata;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_v  [2];
  logic       start_v  [2];
  logic       write_v  [2];
  logic [7:0] addr_v   [2];
  logic [2:0] blen_v   [2];
  logic [7:0] wdata_v  [2];
  logic [7:0] bus_in_v [2];
  logic [7:0] rd_model [2];
  logic [7:0] words    [8];
  logic [2:0] state_a, state_b;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  mux_bus_if #(.DATA_W(8), .BL_W(3)) ifa ();
  mux_bus_if #(.DATA_W(8), .BL_W(3)) ifb ();

  assign ifa.start     = start_v[0];
  assign ifa.write     = write_v[0];
  assign ifa.addr      = addr_v[0];
  assign ifa.burst_len = blen_v[0];
  assign ifa.wdata     = wdata_v[0];
  assign ifa.bus_in    = bus_in_v[0];
  assign ifb.start     = start_v[1];
  assign ifb.write     = write_v[1];
  assign ifb.addr      = addr_v[1];
  assign ifb.burst_len = blen_v[1];
  assign ifb.wdata     = wdata_v[1];
  assign ifb.bus_in    = bus_in_v[1];

  mux_bus_master #(
    .DATA_W(8), .BL_W(3), .T_TURN(5), .T_ADDR(25), .T_HIZ(25),
    .T_DATA(25), .T_RECOV(25), .CNT_W(6)
  ) dut_a (
    .clk(clk), .reset(reset_v[0]), .bus(ifa), .state(state_a)
  );

  mux_bus_master #(
    .DATA_W(8), .BL_W(3), .T_TURN(1), .T_ADDR(2), .T_HIZ(1),
    .T_DATA(3), .T_RECOV(1), .CNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset_v[1]), .bus(ifb), .state(state_b)
  );

  // Phase order within a beat: TURN_A, ADDR, TURN_B, HIZ, XFER, RECOV.
  function automatic int tlen(input int sel, input int ph);
    if (sel == 0) begin
      case (ph)
        0, 2:    return 5;
        default: return 25;
      endcase
    end else begin
      case (ph)
        1:       return 2;
        4:       return 3;
        default: return 1;
      endcase
    end
  endfunction

  function automatic ctl_t obs(input int sel);
    ctl_t o;
    if (sel == 0)
      o = {state_a, ifa.CS, ifa.RD, ifa.WR, ifa.AD, ifa.bus_oe, ifa.busy,
           ifa.done, ifa.wdata_ack, ifa.rdata_valid, ifa.rdata};
    else
      o = {state_b, ifb.CS, ifb.RD, ifb.WR, ifb.AD, ifb.bus_oe, ifb.busy,
           ifb.done, ifb.wdata_ack, ifb.rdata_valid, ifb.rdata};
    return o;
  endfunction

  function automatic logic [7:0] obs_bus(input int sel);
    return (sel == 0) ? ifa.bus_out : ifb.bus_out;
  endfunction

  task automatic chk_ctl(input string tag, input int sel, input int t,
                         input ctl_t o, input ctl_t e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0d: got st/cs/rd/wr/ad/oe/busy/done/ack/rv/rdata=%b expected %b",
             tag, sel, t, o, e);
    end
  endtask

  task automatic chk8(input string tag, input int sel, input int t,
                      input logic [7:0] o, input logic [7:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0d: got %h expected %h", tag, sel, t, o, e);
    end
  endtask

  task automatic idle(input int sel, input int k);
    ctl_t e;
    start_v[sel] = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      e = {3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd_model[sel]};
      chk_ctl("idle", sel, i, obs(sel), e);
    end
  endtask

  task automatic fill_words();
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
  endtask

  // Issues start at the current negedge and checks every cycle of the
  // transaction plus the done cycle. abort_t >= 0 asserts reset during that
  // cycle instead of finishing. noise scrambles request inputs and pulses
  // start while busy.
  task automatic run_txn(input int sel, input bit wr, input logic [7:0] a0,
                         input int blen, input int abort_t, input bit noise);
    int bl, n, beat, p, ph, off;
    logic rv, ack;
    logic [7:0] eb;
    ctl_t e;
    bl = 0;
    for (int i = 0; i < 6; i++) bl += tlen(sel, i);
    n = (blen + 1) * bl;
    start_v[sel]  = 1'b1;
    write_v[sel]  = wr;
    addr_v[sel]   = a0;
    blen_v[sel]   = 3'(blen);
    wdata_v[sel]  = words[0];
    bus_in_v[sel] = 8'($urandom);
    @(posedge clk);
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t == n) begin
        e = {3'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rd_model[sel]};
        chk_ctl("done", sel, t, obs(sel), e);
        start_v[sel] = 1'b0;
      end else begin
        beat = t / bl;
        p    = t % bl;
        ph   = 0;
        off  = p;
        while (off >= tlen(sel, ph)) begin
          off -= tlen(sel, ph);
          ph++;
        end
        ack = wr && (p == 0);
        rv  = !wr && (ph == 5) && (off == 0);
        if (rv) rd_model[sel] = words[beat];
        e = {3'(ph + 1),
             !(ph == 1 || ph == 4),
             !(ph == 4 && !wr),
             !(ph == 1 || (ph == 4 && wr)),
             !(ph <= 2),
             (ph <= 2) || (ph == 4 && wr),
             1'b1, 1'b0, ack, rv, rd_model[sel]};
        chk_ctl("beat", sel, t, obs(sel), e);
        if (ph <= 2 || (ph == 4 && wr)) begin
          eb = (ph <= 2) ? 8'(a0 + beat) : words[beat];
          chk8("bus_out", sel, t, obs_bus(sel), eb);
        end
        if (t == abort_t) begin
          reset_v[sel] = 1'b1;
          start_v[sel] = 1'b0;
          @(negedge clk);
          rd_model[sel] = 8'h00;
          e = {3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
          chk_ctl("abort", sel, t + 1, obs(sel), e);
          chk8("abort_bus", sel, t + 1, obs_bus(sel), 8'h00);
          reset_v[sel] = 1'b0;
          idle(sel, 4);
          return;
        end
        bus_in_v[sel] = (ph == 4) ? words[beat] : 8'($urandom);
        wdata_v[sel]  = (ph == 5 && off == tlen(sel, 5) - 1 && beat < blen)
                        ? words[beat + 1] : 8'($urandom);
        if (noise) begin
          write_v[sel] = 1'($urandom);
          addr_v[sel]  = 8'($urandom);
          blen_v[sel]  = 3'($urandom);
        end
        start_v[sel] = (noise && t < n - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  endtask

  initial begin
    int gap;
    ctl_t e;
    for (int s = 0; s < 2; s++) begin
      reset_v[s]  = 1'b1;
      start_v[s]  = 1'b0;
      write_v[s]  = 1'b0;
      addr_v[s]   = 8'h00;
      blen_v[s]   = 3'd0;
      wdata_v[s]  = 8'h00;
      bus_in_v[s] = 8'h00;
      rd_model[s] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      e = {3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      chk_ctl("reset", s, 0, obs(s), e);
      chk8("reset_bus", s, 0, obs_bus(s), 8'h00);
    end
    reset_v[0] = 1'b0;
    reset_v[1] = 1'b0;
    idle(0, 2);
    idle(1, 2);

    // Default timing: directed transactions.
    words[0] = 8'h5C;
    run_txn(0, 1'b1, 8'h3A, 0, -1, 1'b0);
    idle(0, 3);
    words[0] = 8'hA7;
    run_txn(0, 1'b0, 8'h10, 0, -1, 1'b0);
    idle(0, 2);
    fill_words();
    run_txn(0, 1'b0, 8'hFE, 2, -1, 1'b1);
    idle(0, 1);
    // Reset during the 10th XFER cycle of a write (XFER starts at offset 60).
    fill_words();
    run_txn(0, 1'b1, 8'($urandom), 0, 69, 1'b1);
    fill_words();
    run_txn(0, 1'b0, 8'($urandom), 1, -1, 1'b1);
    idle(0, 1);

    // Short timing: random bursts, some back-to-back.
    for (int k = 0; k < 30; k++) begin
      fill_words();
      run_txn(1, 1'($urandom), 8'($urandom), $urandom_range(0, 7), -1, 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(1, gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
